// File: rtl/ssp_uart_reg_arbiter.sv
// rtl/ssp_uart_reg_arbiter.sv - round-robin arbiter framing two requesters onto the ssp_uart SSP slave port
module ssp_uart_reg_arbiter #(
   parameter int         XFER_CYCLES = 12,
   parameter logic [2:0] MAX_RA      = 3'b100
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_ra,
   input  logic        req0_wnr,
   input  logic [11:0] req0_wdata,
   output logic        rsp0_valid,
   output logic [11:0] rsp0_rdata,
   output logic        rsp0_err,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_ra,
   input  logic        req1_wnr,
   input  logic [11:0] req1_wdata,
   output logic        rsp1_valid,
   output logic [11:0] rsp1_rdata,
   output logic        rsp1_err,
   output logic        ssp_ssel,
   output logic        ssp_en,
   output logic        ssp_eoc,
   output logic [2:0]  ssp_ra,
   output logic        ssp_wnr,
   output logic [11:0] ssp_di,
   input  logic [11:0] ssp_do,
   output logic        busy,
   output logic        grant
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_XFER, S_EOC, S_DONE, S_ERR
   } state_t;

   localparam logic [7:0] LP_LOAD = 8'(XFER_CYCLES - 1);

   state_t      r_state;
   logic        r_prio;
   logic [7:0]  r_cnt;
   logic        r_grant;
   logic        r_busy;
   logic        r_ssel;
   logic        r_en;
   logic        r_eoc;
   logic [2:0]  r_ra;
   logic        r_wnr;
   logic [11:0] r_di;
   logic        r_rsp0_valid;
   logic        r_rsp1_valid;
   logic        r_err;
   logic [11:0] r_rdata;

   logic        w_any;
   logic        w_win;
   logic        w_acc;
   logic [2:0]  w_ra;
   logic        w_wnr;
   logic [11:0] w_wdata;

   // Winner is the rotating priority only when both ask; a lone requester always wins.
   assign w_any   = req0_valid | req1_valid;
   assign w_win   = (req0_valid & req1_valid) ? r_prio : req1_valid;
   assign w_acc   = (r_state == S_IDLE) & w_any & ~Rst;
   assign w_ra    = w_win ? req1_ra    : req0_ra;
   assign w_wnr   = w_win ? req1_wnr   : req0_wnr;
   assign w_wdata = w_win ? req1_wdata : req0_wdata;

   assign req0_ready = w_acc & ~w_win;
   assign req1_ready = w_acc &  w_win;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state      <= S_IDLE;
         r_prio       <= 1'b0;
         r_cnt        <= 8'd0;
         r_grant      <= 1'b0;
         r_busy       <= 1'b0;
         r_ssel       <= 1'b0;
         r_en         <= 1'b0;
         r_eoc        <= 1'b0;
         r_ra         <= 3'd0;
         r_wnr        <= 1'b0;
         r_di         <= 12'd0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_err        <= 1'b0;
         r_rdata      <= 12'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant <= w_win;
                  r_prio  <= ~w_win;
                  r_busy  <= 1'b1;
                  if (w_ra > MAX_RA) begin
                     r_state      <= S_ERR;
                     r_rsp0_valid <= ~w_win;
                     r_rsp1_valid <= w_win;
                     r_err        <= 1'b1;
                  end else begin
                     r_state <= S_SETUP;
                     r_ssel  <= 1'b1;
                     r_ra    <= w_ra;
                     r_wnr   <= w_wnr;
                     r_di    <= w_wnr ? w_wdata : 12'd0;
                  end
               end
            end
            S_SETUP: begin
               r_state <= S_XFER;
               r_en    <= 1'b1;
               r_cnt   <= LP_LOAD;
            end
            S_XFER: begin
               if (r_cnt == 8'd0) begin
                  r_state <= S_EOC;
                  r_en    <= 1'b0;
                  r_eoc   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_EOC: begin
               // Read data is captured on the edge that closes the EOC strobe.
               r_state      <= S_DONE;
               r_eoc        <= 1'b0;
               r_ssel       <= 1'b0;
               r_ra         <= 3'd0;
               r_wnr        <= 1'b0;
               r_di         <= 12'd0;
               r_rsp0_valid <= ~r_grant;
               r_rsp1_valid <= r_grant;
               r_rdata      <= r_wnr ? 12'd0 : ssp_do;
            end
            S_DONE, S_ERR: begin
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_rsp0_valid <= 1'b0;
               r_rsp1_valid <= 1'b0;
               r_err        <= 1'b0;
               r_rdata      <= 12'd0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp0_rdata = r_rsp0_valid ? r_rdata : 12'd0;
   assign rsp1_rdata = r_rsp1_valid ? r_rdata : 12'd0;
   assign rsp0_err   = r_rsp0_valid & r_err;
   assign rsp1_err   = r_rsp1_valid & r_err;
   assign ssp_ssel   = r_ssel;
   assign ssp_en     = r_en;
   assign ssp_eoc    = r_eoc;
   assign ssp_ra     = r_ra;
   assign ssp_wnr    = r_wnr;
   assign ssp_di     = r_di;
   assign busy       = r_busy;
   assign grant      = r_grant;

endmodule

// File: tb/tb_ssp_uart_reg_arbiter.sv
// tb/tb_ssp_uart_reg_arbiter.sv - directed-vector bench for ssp_uart_reg_arbiter
module tb_ssp_uart_reg_arbiter;
   localparam int N = 12;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        req0_valid, req0_ready, req0_wnr, rsp0_valid, rsp0_err;
   logic [2:0]  req0_ra;
   logic [11:0] req0_wdata, rsp0_rdata;
   logic        req1_valid, req1_ready, req1_wnr, rsp1_valid, rsp1_err;
   logic [2:0]  req1_ra;
   logic [11:0] req1_wdata, rsp1_rdata;
   logic        ssp_ssel, ssp_en, ssp_eoc, ssp_wnr, busy, grant;
   logic [2:0]  ssp_ra;
   logic [11:0] ssp_di, ssp_do;

   ssp_uart_reg_arbiter #(.XFER_CYCLES(N), .MAX_RA(3'b100)) dut (
      .Clk(Clk), .Rst(Rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ra(req0_ra),
      .req0_wnr(req0_wnr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ra(req1_ra),
      .req1_wnr(req1_wnr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .ssp_ssel(ssp_ssel), .ssp_en(ssp_en), .ssp_eoc(ssp_eoc), .ssp_ra(ssp_ra),
      .ssp_wnr(ssp_wnr), .ssp_di(ssp_di), .ssp_do(ssp_do),
      .busy(busy), .grant(grant)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [2:0]  pra [2];
   logic        pwnr[2];
   logic [11:0] pwd [2];

   task automatic drive(input int who, input logic v);
      if (who == 0) begin
         req0_valid = v; req0_ra = pra[0]; req0_wnr = pwnr[0]; req0_wdata = pwd[0];
      end else begin
         req1_valid = v; req1_ra = pra[1]; req1_wnr = pwnr[1]; req1_wdata = pwd[1];
      end
   endtask

   // Returns inside the handshake cycle, just before the accepting edge.
   task automatic wait_hs(output int who, output int at);
      who = -1;
      at  = 0;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (req0_ready || req1_ready) begin
            chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
            who = req1_ready ? 1 : 0;
            at  = cyc;
            return;
         end
         @(negedge Clk);
      end
      chk("hs_timeout", 32'd0, 32'd1);
   endtask

   task automatic watch(input int who, input logic legal, input logic [11:0] do_val,
                        input logic [11:0] exp_rd);
      int          last;
      logic        s, r;
      logic [11:0] exp_di;
      last   = legal ? N + 3 : 1;
      exp_di = pwnr[who] ? pwd[who] : 12'd0;
      for (int k = 1; k <= last; k++) begin
         @(negedge Clk);
         ssp_do = (k == N + 2) ? do_val : 12'hFFF;
         s = legal && (k <= N + 2);
         r = (k == last);
         chk("ssel", 32'(ssp_ssel), 32'(s));
         chk("en",   32'(ssp_en),   32'(legal && k >= 2 && k <= N + 1));
         chk("eoc",  32'(ssp_eoc),  32'(legal && k == N + 2));
         chk("ra",   32'(ssp_ra),   32'(s ? pra[who] : 3'd0));
         chk("wnr",  32'(ssp_wnr),  32'(s ? pwnr[who] : 1'b0));
         chk("di",   32'(ssp_di),   32'(s ? exp_di : 12'd0));
         chk("busy", 32'(busy),     32'd1);
         chk("grant", 32'(grant),   32'(who));
         chk("rsp0_valid", 32'(rsp0_valid), 32'(r && who == 0));
         chk("rsp1_valid", 32'(rsp1_valid), 32'(r && who == 1));
         if (r) begin
            chk("rdata", 32'(who == 1 ? rsp1_rdata : rsp0_rdata), 32'(exp_rd));
            chk("err",   32'(who == 1 ? rsp1_err : rsp0_err),     32'(!legal));
         end
      end
   endtask

   int who, t, tp;

   initial begin
      req0_valid = 0; req0_ra = 0; req0_wnr = 0; req0_wdata = 0;
      req1_valid = 0; req1_ra = 0; req1_wnr = 0; req1_wdata = 0;
      ssp_do = 12'hFFF;
      pra[0] = 0; pwnr[0] = 0; pwd[0] = 0;
      pra[1] = 0; pwnr[1] = 0; pwd[1] = 0;

      // Reset state, ready suppressed even with a valid request pending.
      req0_valid = 1;
      repeat (3) @(negedge Clk);
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ssel",   32'(ssp_ssel),   32'd0);
      chk("rst_en",     32'(ssp_en),     32'd0);
      chk("rst_eoc",    32'(ssp_eoc),    32'd0);
      chk("rst_busy",   32'(busy),       32'd0);
      chk("rst_grant",  32'(grant),      32'd0);
      chk("rst_rsp",    32'({rsp0_valid, rsp1_valid}), 32'd0);
      req0_valid = 0;
      Rst = 0;
      @(negedge Clk);

      // Write from requester 0.
      pra[0] = 3'b000; pwnr[0] = 1; pwd[0] = 12'h5A3;
      drive(0, 1);
      wait_hs(who, t);
      chk("t1_who", 32'(who), 32'd0);
      if (who >= 0) watch(who, 1'b1, 12'h3C3, 12'h000);
      drive(0, 0);

      // Read from requester 1; wdata must not leak onto ssp_di.
      pra[1] = 3'b011; pwnr[1] = 0; pwd[1] = 12'hABC;
      drive(1, 1);
      wait_hs(who, t);
      chk("t2_who", 32'(who), 32'd1);
      if (who >= 0) watch(who, 1'b1, 12'h0C7, 12'h0C7);
      drive(1, 0);

      // Illegal address.
      pra[0] = 3'b110; pwnr[0] = 0; pwd[0] = 12'h000;
      drive(0, 1);
      wait_hs(who, t);
      chk("t4_who", 32'(who), 32'd0);
      if (who >= 0) watch(who, 1'b0, 12'h000, 12'h000);
      drive(0, 0);
      @(negedge Clk);
      chk("t4_idle_busy", 32'(busy), 32'd0);
      chk("t4_idle_rsp0", 32'(rsp0_valid), 32'd0);

      // Async reset mid-XFER, between clock edges.
      pra[0] = 3'b010; pwnr[0] = 1; pwd[0] = 12'h111;
      drive(0, 1);
      wait_hs(who, t);
      chk("t5_who", 32'(who), 32'd0);
      repeat (5) @(negedge Clk);
      chk("t5_pre_en", 32'(ssp_en), 32'd1);
      #2 Rst = 1;
      #1;
      chk("t5_ssel", 32'(ssp_ssel), 32'd0);
      chk("t5_en",   32'(ssp_en),   32'd0);
      chk("t5_busy", 32'(busy),     32'd0);
      drive(0, 0);
      repeat (N + 4) begin
         @(negedge Clk);
         chk("t5_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      end
      Rst = 0;

      // Fairness after reset: both held valid, grants alternate from 0.
      pra[0] = 3'b001; pwnr[0] = 1; pwd[0] = 12'h2A5;
      pra[1] = 3'b100; pwnr[1] = 0; pwd[1] = 12'h777;
      drive(0, 1);
      drive(1, 1);
      tp = 0;
      for (int i = 0; i < 4; i++) begin
         wait_hs(who, t);
         chk("fair_who", 32'(who), 32'(i % 2));
         if (i > 0) chk("fair_gap", 32'(t - tp), 32'(N + 4));
         tp = t;
         if (who >= 0) watch(who, 1'b1, who == 1 ? 12'h456 : 12'h999, who == 1 ? 12'h456 : 12'h000);
      end
      drive(0, 0);

      // Requester 1 streaming alone, then requester 0 joins and wins on prio.
      pra[1] = 3'b001; pwnr[1] = 0; pwd[1] = 12'h000;
      drive(1, 1);
      for (int i = 0; i < 3; i++) begin
         wait_hs(who, t);
         chk("stream_who", 32'(who), 32'd1);
         if (i > 0) chk("stream_gap", 32'(t - tp), 32'(N + 4));
         tp = t;
         if (who >= 0) watch(who, 1'b1, 12'h0F0, 12'h0F0);
      end
      drive(0, 1);
      wait_hs(who, t);
      chk("prio_after_stream", 32'(who), 32'd0);
      chk("prio_gap", 32'(t - tp), 32'(N + 4));
      if (who >= 0) watch(who, 1'b1, 12'h000, 12'h000);
      drive(0, 0);
      drive(1, 0);
      @(negedge Clk);
      @(negedge Clk);
      chk("end_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ssp_uart_reg_arbiter.md
Name: ssp_uart_reg_arbiter

Overview:
Arbitrates and sequences register accesses to the ssp_uart SSP slave port. Two requesters, requester 0 (host/test sequencer) and requester 1 (autonomous FIFO service engine), share it round-robin. Each accepted request becomes one framed SSP transaction (SSEL/En/EOC) addressed to UCR/USR/TDR/RDR/SPR. The read data or a completion status is returned to the originating requester. The block sits between the requesters and the ssp_uart SSP_* inputs.

Parameters:
XFER_CYCLES, 12, number of cycles ssp_en is held high per transaction (one per data bit, legal range 1..255)
MAX_RA, 3'b100, highest legal register address (SPR); addresses above it are rejected

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a request
req0_ready  out  1  request 0 accepted this cycle
req0_ra  in  3  register address
req0_wnr  in  1  1=write, 0=read
req0_wdata  in  12  write data
rsp0_valid  out  1  one-cycle completion pulse for requester 0
rsp0_rdata  out  12  read data (0 for writes/errors)
rsp0_err  out  1  illegal address, qualified by rsp0_valid
req1_valid, req1_ready, req1_ra, req1_wnr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err: identical to the requester 0 signals, for requester 1
ssp_ssel  out  1  SSP slave select
ssp_en  out  1  SSP transfer enable
ssp_eoc  out  1  end-of-cycle strobe
ssp_ra  out  3  register address to DUT
ssp_wnr  out  1  direction to DUT
ssp_di  out  12  write data to DUT
ssp_do  in  12  read data from DUT
busy  out  1  FSM not in IDLE
grant  out  1  index of requester owning current/last transaction

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst is asynchronous and active-high.
- Reset values: all outputs 0; FSM=IDLE; round-robin pointer prio=0; bit counter=0.
  - Rst asserted mid-transaction forces outputs to 0 immediately, without waiting for a clock edge.
  - The in-flight request is dropped; no rsp is issued for it.
- FSM states: IDLE, SETUP, XFER, EOC, DONE, ERR.
- IDLE, arbitration:
  - If any req_valid is high, select the winner combinationally and assert its reqN_ready in the same cycle.
  - Latch ra/wnr/wdata and set grant.
  - With both requesters valid, the winner is prio. With one valid, that requester wins.
  - After any grant, prio = ~winner.
- IDLE next state: ra>MAX_RA -> ERR, otherwise -> SETUP.
- SETUP (1 cycle): ssp_ssel=1; ssp_ra/ssp_wnr/ssp_di driven from the latch; ssp_en=0.
- XFER (XFER_CYCLES cycles): ssp_ssel=1, ssp_en=1. Counter loads XFER_CYCLES-1 on entry and decrements; the state exits at 0.
- EOC (1 cycle): ssp_ssel=1, ssp_en=0, ssp_eoc=1. For reads, ssp_do is registered at the end of this cycle.
- DONE (1 cycle): ssp_ssel=0; rspN_valid=1 for grant; rspN_rdata = sampled value (read) or 0 (write); rspN_err=0. Next state -> IDLE.
- ERR (1 cycle): no SSP activity; rspN_valid=1, rspN_err=1, rdata=0. Next state -> IDLE.
- Output stability: ssp_ra/ssp_wnr/ssp_di are stable from SETUP through EOC and are 0 in IDLE/DONE/ERR. ssp_di is 0 for reads.
- Latency: with handshake in cycle T, SETUP=T+1, XFER=T+2..T+1+N, EOC=T+2+N, rsp=T+3+N (N=XFER_CYCLES). The next handshake is possible at T+4+N at the earliest.
- Back-pressure: reqN_ready is only ever high in IDLE. Requesters hold valid and payload until ready. A valid withdrawn before ready is simply not served.
- Response rules: rsp pulses only to the granted requester. The two rsp_valid outputs are never high together.
- busy=1 in all states except IDLE.

Test Plan:
1. Write, N=12: req0 RA=3'b000, wnr=1, wdata=12'h5A3, handshake at T -> ssp_ssel high T+1..T+14, ssp_en high T+2..T+13, ssp_eoc at T+14, ssp_di=12'h5A3 T+1..T+14, rsp0_valid at T+15 with rdata=0, err=0.
2. Read: req1 RA=3'b011, wnr=0, bench drives ssp_do=12'h0C7 during EOC -> rsp1_valid at T+15 with rsp1_rdata=12'h0C7; ssp_di=0 throughout.
3. Fairness: after reset, both requesters valid continuously -> grants alternate 0,1,0,1; each handshake is 16 cycles apart; rsp pulses go to the matching requester.
4. Illegal address: req0 RA=3'b110 -> ready at T, no ssp_ssel/en/eoc, rsp0_valid=1 with rsp0_err=1 at T+1, rdata=0, then IDLE.
5. Async reset: assert Rst mid-XFER between clock edges -> ssp_ssel/ssp_en/busy fall immediately, no rsp. After release, simultaneous req0/req1 -> req0 granted first.
6. Single requester streaming: req1 only, valid held high -> back-to-back transactions every N+4 cycles, grant stays 1, prio=0 after each grant.
